nanorv32_rf_ctxsw: RTL and testbench

Context save/restore engine for the NANORV32 register file. On request it walks a contiguous range of integer registers. A save reads each register through register-file read port A and stores it to memory. A restore loads each word from memory and writes it back through register-file write port rd. It sits beside the core datapath, owns the register-file select/write ports while busy, and is used by interrupt entry/exit and context-switch micro-sequences.

---
 rtl/nanorv32_rf_ctxsw.sv | 139 +++++++++++++
 tb/tb_nanorv32_rf_ctxsw.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nanorv32_rf_ctxsw.sv
// rtl/nanorv32_rf_ctxsw.sv - register-file context save/restore engine for NANORV32
module nanorv32_rf_ctxsw #(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        save_req,
    input  logic        restore_req,
    input  logic [31:0] sp_base,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_sel_porta,
    input  logic [31:0] rf_porta,
    output logic [4:0]  rf_sel_rd,
    output logic [31:0] rf_rd,
    output logic        rf_write_rd,
    output logic        rf_allow_x0,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAVE    = 2'd1,
        S_RESTORE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);
    // x0 is only reachable when the frame explicitly starts at it
    localparam logic       X0_IN_FRAME = (FIRST_REG == 0) ? 1'b1 : 1'b0;

    state_t      state;
    state_t      next_state;
    logic [4:0]  cur;
    logic [31:0] base;
    logic [31:0] off;
    logic        active;
    logic        start;
    logic        xfer;
    logic        last_reg;

    assign active   = (state == S_SAVE) || (state == S_RESTORE);
    assign start    = (state == S_IDLE) && (save_req || restore_req);
    // mem_ready only counts while a transfer is being requested
    assign xfer     = active && mem_ready;
    assign last_reg = (cur == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Frame walk registers: latch base on start, step index/offset per completed transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur  <= 5'd0;
            base <= 32'd0;
            off  <= 32'd0;
        end else if (start) begin
            cur  <= FIRST_IDX;
            base <= {sp_base[31:2], 2'b00};
            off  <= 32'd0;
        end else if (xfer && !last_reg) begin
            cur  <= cur + 5'd1;
            off  <= off + 32'd4;
        end
    end

    // Next-state: save has priority; requests outside IDLE are dropped
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (save_req) begin
                    next_state = S_SAVE;
                end else if (restore_req) begin
                    next_state = S_RESTORE;
                end
            end
            S_SAVE, S_RESTORE: begin
                if (xfer && last_reg) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs: everything idles at zero outside the active states
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        rf_sel_porta = 5'd0;
        rf_sel_rd    = 5'd0;
        rf_rd        = 32'd0;
        rf_write_rd  = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        case (state)
            S_SAVE: begin
                busy         = 1'b1;
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr     = base + off;
                rf_sel_porta = cur;
                mem_wdata    = rf_porta;
            end
            S_RESTORE: begin
                busy         = 1'b1;
                mem_req      = 1'b1;
                mem_addr     = base + off;
                rf_sel_rd    = cur;
                rf_rd        = mem_rdata;
                rf_write_rd  = mem_ready;
            end
            S_DONE: begin
                done         = 1'b1;
            end
            default: begin
            end
        endcase
        rf_allow_x0 = busy && X0_IN_FRAME;
    end

endmodule

// File: tb/tb_nanorv32_rf_ctxsw.sv
// tb/tb_nanorv32_rf_ctxsw.sv - randomized self-checking bench for nanorv32_rf_ctxsw
module tb_nanorv32_rf_ctxsw;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        save_req, restore_req;
    logic [31:0] sp_base;
    logic        busy, done, rf_write_rd, rf_allow_x0, mem_req, mem_we, mem_ready;
    logic [4:0]  rf_sel_porta, rf_sel_rd;
    logic [31:0] rf_porta, rf_rd, mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    // Behavioural register file and 256-word memory window, owned by one process
    logic [31:0] rf [32];
    logic [31:0] mem [256];
    logic [31:0] rf_stage [32];
    logic [31:0] mem_stage [256];
    logic        load_rf = 1'b0, load_mem = 1'b0;
    int          wait_cycles = 0;
    int          wcnt;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic        log_we[$];

    assign mem_ready = mem_req && (wcnt >= wait_cycles);
    assign mem_rdata = mem[mem_addr[9:2]];
    assign rf_porta  = (rf_sel_porta == 5'd0 && !rf_allow_x0) ? 32'h0 : rf[rf_sel_porta];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= 0;
        end else begin
            if (load_rf)  rf  <= rf_stage;
            if (load_mem) mem <= mem_stage;
            if (rf_write_rd && (rf_sel_rd != 5'd0 || rf_allow_x0)) rf[rf_sel_rd] <= rf_rd;
            if (mem_req) begin
                if (mem_ready) begin
                    wcnt <= 0;
                    log_addr.push_back(mem_addr);
                    log_data.push_back(mem_we ? mem_wdata : mem_rdata);
                    log_we.push_back(mem_we);
                    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    nanorv32_rf_ctxsw dut (
        .clk(clk), .rst_n(rst_n), .save_req(save_req), .restore_req(restore_req),
        .sp_base(sp_base), .busy(busy), .done(done), .rf_sel_porta(rf_sel_porta),
        .rf_porta(rf_porta), .rf_sel_rd(rf_sel_rd), .rf_rd(rf_rd), .rf_write_rd(rf_write_rd),
        .rf_allow_x0(rf_allow_x0), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // Boundary-frame instances with an always-ready memory
    logic        b_save = 1'b0, b_restore = 1'b0, b_ready = 1'b1;
    logic [31:0] b_sp0 = 32'h0, b_sp1 = 32'h0, b_rdata = 32'h0;
    logic        b0_busy, b0_done, b0_wr, b0_ax, b0_req, b0_we;
    logic [4:0]  b0_sela, b0_selrd;
    logic [31:0] b0_porta, b0_rd, b0_addr, b0_wdata;
    logic        b1_busy, b1_done, b1_wr, b1_ax, b1_req, b1_we;
    logic [4:0]  b1_sela, b1_selrd;
    logic [31:0] b1_porta, b1_rd, b1_addr, b1_wdata;

    assign b0_porta = 32'h1234_5678;
    assign b1_porta = 32'hB000_0000 | {27'h0, b1_sela};

    nanorv32_rf_ctxsw #(.FIRST_REG(0), .LAST_REG(0)) dut_b0 (
        .clk(clk), .rst_n(rst_n), .save_req(b_save), .restore_req(b_restore), .sp_base(b_sp0),
        .busy(b0_busy), .done(b0_done), .rf_sel_porta(b0_sela), .rf_porta(b0_porta),
        .rf_sel_rd(b0_selrd), .rf_rd(b0_rd), .rf_write_rd(b0_wr), .rf_allow_x0(b0_ax),
        .mem_req(b0_req), .mem_we(b0_we), .mem_addr(b0_addr), .mem_wdata(b0_wdata),
        .mem_rdata(b_rdata), .mem_ready(b_ready)
    );

    nanorv32_rf_ctxsw #(.FIRST_REG(30), .LAST_REG(31)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .save_req(b_save), .restore_req(b_restore), .sp_base(b_sp1),
        .busy(b1_busy), .done(b1_done), .rf_sel_porta(b1_sela), .rf_porta(b1_porta),
        .rf_sel_rd(b1_selrd), .rf_rd(b1_rd), .rf_write_rd(b1_wr), .rf_allow_x0(b1_ax),
        .mem_req(b1_req), .mem_we(b1_we), .mem_addr(b1_addr), .mem_wdata(b1_wdata),
        .mem_rdata(b_rdata), .mem_ready(b_ready)
    );

    logic [111:0] outs;
    assign outs = {busy, done, mem_req, mem_we, mem_addr, mem_wdata, rf_sel_porta,
                   rf_sel_rd, rf_rd, rf_write_rd, rf_allow_x0};

    task automatic push_stage(input bit r, input bit m);
        @(negedge clk); load_rf = r; load_mem = m;
        @(negedge clk); load_rf = 1'b0; load_mem = 1'b0;
    endtask

    // Issue a request and follow the frame cycle by cycle; e counts edges after the start edge
    task automatic run_op(input bit do_save, input bit do_restore, input int max_cyc, input bit poke,
                          output int done_at, output int busy_n, output bit ax_seen);
        bit          hold;
        logic [31:0] h_addr, h_data;
        logic        h_we;
        done_at = -1; busy_n = 0; ax_seen = 1'b0; hold = 1'b0;
        h_addr = '0; h_data = '0; h_we = 1'b0;
        @(negedge clk); save_req = do_save; restore_req = do_restore;
        @(negedge clk); save_req = 1'b0; restore_req = 1'b0;
        for (int e = 1; e <= max_cyc && done_at < 0; e++) begin
            if (e > 1) @(negedge clk);
            restore_req = 1'b0;
            if (busy) busy_n++;
            if (rf_allow_x0) ax_seen = 1'b1;
            if (hold && mem_req) begin
                checks++;
                if (mem_addr !== h_addr || mem_wdata !== h_data || mem_we !== h_we) begin
                    errors++;
                    $display("FAIL hold_stable: addr=%h wdata=%h we=%b required addr=%h wdata=%h we=%b",
                             mem_addr, mem_wdata, mem_we, h_addr, h_data, h_we);
                end
            end
            hold = mem_req && !mem_ready;
            h_addr = mem_addr; h_data = mem_wdata; h_we = mem_we;
            if (poke && e == 10) restore_req = 1'b1;
            if (done) begin
                done_at = e;
                if (poke) restore_req = 1'b1;
            end
        end
        @(negedge clk); restore_req = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL reset_outputs: got=%h required=0", outs);
        end
        checks++;
        if ({b0_busy, b0_req, b0_ax, b1_busy, b1_req, b1_addr} !== '0) begin
            errors++; $display("FAIL reset_boundary_outputs: b0_busy=%b b1_addr=%h required 0", b0_busy, b1_addr);
        end
    endtask

    task automatic test_save(input int w, input bit poke, input bit both, input string tag);
        logic [31:0] exp_a;
        int st, d, b;
        bit ax;
        rf_stage[0] = 32'h0;
        for (int k = 1; k < 32; k++) rf_stage[k] = 32'hA000_0000 + 32'(k);
        push_stage(1'b1, 1'b0);
        wait_cycles = w; sp_base = 32'h0000_1000; st = log_addr.size();
        run_op(1'b1, both, 400, poke, d, b, ax);
        checks++;
        if (d !== 31 * (w + 1) + 1) begin
            errors++; $display("FAIL %s_done_cycle: got=%0d required=%0d", tag, d, 31 * (w + 1) + 1);
        end
        checks++;
        if (b !== 31 * (w + 1)) begin
            errors++; $display("FAIL %s_busy_cycles: got=%0d required=%0d", tag, b, 31 * (w + 1));
        end
        checks++;
        if (log_addr.size() - st !== 31) begin
            errors++; $display("FAIL %s_transfer_count: got=%0d required=31", tag, log_addr.size() - st);
        end
        for (int k = 1; k < 32; k++) begin
            exp_a = 32'h0000_1000 + 32'(4 * (k - 1));
            checks++;
            if (log_addr[st+k-1] !== exp_a || log_data[st+k-1] !== 32'hA000_0000 + 32'(k) || log_we[st+k-1] !== 1'b1) begin
                errors++;
                $display("FAIL %s_store_x%0d: addr=%h data=%h we=%b required addr=%h data=%h we=1",
                         tag, k, log_addr[st+k-1], log_data[st+k-1], log_we[st+k-1], exp_a, 32'hA000_0000 + 32'(k));
            end
        end
        st = log_addr.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || log_addr.size() !== st) begin
                errors++; $display("FAIL %s_no_followup: busy=%b done=%b extra=%0d required idle", tag, busy, done, log_addr.size() - st);
            end
        end
    endtask

    task automatic test_restore;
        int d, b;
        bit ax;
        for (int k = 1; k < 32; k++) begin
            mem_stage[(32'h2000 + 32'(4 * (k - 1))) >> 2 & 32'hFF] = 32'h5A00_0000 + 32'(k);
            rf_stage[k] = 32'hDEAD_0000 + 32'(k);
        end
        rf_stage[0] = 32'h0;
        push_stage(1'b1, 1'b1);
        wait_cycles = 0; sp_base = 32'h0000_2000;
        run_op(1'b0, 1'b1, 200, 1'b0, d, b, ax);
        checks++;
        if (d !== 32) begin
            errors++; $display("FAIL restore_done_cycle: got=%0d required=32", d);
        end
        for (int k = 1; k < 32; k++) begin
            checks++;
            if (rf[k] !== 32'h5A00_0000 + 32'(k)) begin
                errors++; $display("FAIL restore_x%0d: got=%h required=%h", k, rf[k], 32'h5A00_0000 + 32'(k));
            end
        end
        checks++;
        if (rf[0] !== 32'h0 || ax !== 1'b0) begin
            errors++; $display("FAIL restore_x0: x0=%h allow_seen=%b required 0/0", rf[0], ax);
        end
    endtask

    task automatic test_boundary;
        @(negedge clk); b_save = 1'b1; b_sp0 = 32'hFFFF_FFFF; b_sp1 = 32'hFFFF_FFFC;
        @(negedge clk); b_save = 1'b0;
        checks++;
        if (b0_req !== 1'b1 || b0_we !== 1'b1 || b0_addr !== 32'hFFFF_FFFC || b0_ax !== 1'b1 || b0_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL bound_x0_store: req=%b we=%b addr=%h allow=%b wdata=%h required 1/1/fffffffc/1/12345678",
                               b0_req, b0_we, b0_addr, b0_ax, b0_wdata);
        end
        checks++;
        if (b1_addr !== 32'hFFFF_FFFC || b1_sela !== 5'd30 || b1_wdata !== 32'hB000_001E || b1_ax !== 1'b0) begin
            errors++; $display("FAIL bound_wrap_first: addr=%h sel=%0d wdata=%h allow=%b required fffffffc/30/b000001e/0",
                               b1_addr, b1_sela, b1_wdata, b1_ax);
        end
        @(negedge clk);
        checks++;
        if (b0_done !== 1'b1 || b0_busy !== 1'b0 || b0_ax !== 1'b0 || b0_req !== 1'b0) begin
            errors++; $display("FAIL bound_x0_done: done=%b busy=%b allow=%b req=%b required 1/0/0/0", b0_done, b0_busy, b0_ax, b0_req);
        end
        checks++;
        if (b1_addr !== 32'h0000_0000 || b1_sela !== 5'd31 || b1_req !== 1'b1 || b1_wdata !== 32'hB000_001F) begin
            errors++; $display("FAIL bound_wrap_second: addr=%h sel=%0d req=%b wdata=%h required 00000000/31/1/b000001f",
                               b1_addr, b1_sela, b1_req, b1_wdata);
        end
        @(negedge clk);
        checks++;
        if (b1_done !== 1'b1 || b1_busy !== 1'b0 || b0_done !== 1'b0) begin
            errors++; $display("FAIL bound_wrap_done: b1_done=%b b1_busy=%b b0_done=%b required 1/0/0", b1_done, b1_busy, b0_done);
        end
    endtask

    task automatic test_random;
        logic [31:0] snap [32];
        logic [31:0] sp, exp_a;
        int w, d, b, st;
        bit ax;
        for (int r = 0; r < 4; r++) begin
            sp = $urandom; w = $urandom_range(0, 3);
            rf_stage[0] = 32'h0;
            for (int k = 1; k < 32; k++) rf_stage[k] = $urandom;
            snap = rf_stage;
            push_stage(1'b1, 1'b0);
            wait_cycles = w; sp_base = sp; st = log_addr.size();
            run_op(1'b1, 1'b0, 400, 1'b0, d, b, ax);
            checks++;
            if (d !== 31 * (w + 1) + 1) begin
                errors++; $display("FAIL rand%0d_save_done: got=%0d required=%0d", r, d, 31 * (w + 1) + 1);
            end
            for (int k = 1; k < 32; k++) begin
                exp_a = {sp[31:2], 2'b00} + 32'(4 * (k - 1));
                checks++;
                if (log_addr[st+k-1] !== exp_a || log_data[st+k-1] !== snap[k] || log_we[st+k-1] !== 1'b1) begin
                    errors++; $display("FAIL rand%0d_store_x%0d: addr=%h data=%h required addr=%h data=%h",
                                       r, k, log_addr[st+k-1], log_data[st+k-1], exp_a, snap[k]);
                end
            end
            for (int k = 1; k < 32; k++) rf_stage[k] = $urandom;
            push_stage(1'b1, 1'b0);
            run_op(1'b0, 1'b1, 400, 1'b0, d, b, ax);
            checks++;
            if (d !== 31 * (w + 1) + 1 || ax !== 1'b0) begin
                errors++; $display("FAIL rand%0d_restore_done: got=%0d allow=%b required=%0d/0", r, d, ax, 31 * (w + 1) + 1);
            end
            for (int k = 0; k < 32; k++) begin
                checks++;
                if (rf[k] !== snap[k]) begin
                    errors++; $display("FAIL rand%0d_restored_x%0d: got=%h required=%h", r, k, rf[k], snap[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_restore;
        logic [31:0] vals [32];
        bit saw_done;
        int n, d, b;
        bit ax;
        saw_done = 1'b0;
        for (int k = 1; k < 32; k++) begin
            vals[k] = $urandom;
            mem_stage[(32'h3000 + 32'(4 * (k - 1))) >> 2 & 32'hFF] = vals[k];
            rf_stage[k] = 32'hC0DE_0000 + 32'(k);
        end
        rf_stage[0] = 32'h0;
        push_stage(1'b1, 1'b1);
        wait_cycles = 0; sp_base = 32'h0000_3000; n = log_addr.size();
        @(negedge clk); restore_req = 1'b1;
        @(negedge clk); restore_req = 1'b0;
        for (int c = 0; c < 50 && log_addr.size() - n < 5; c++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (log_addr.size() - n !== 5) begin
            errors++; $display("FAIL midrst_progress: loads=%0d required=5", log_addr.size() - n);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL midrst_outputs: got=%h required=0", outs);
        end
        for (int k = 1; k < 32; k++) begin
            checks++;
            if (rf[k] !== ((k <= 5) ? vals[k] : 32'hC0DE_0000 + 32'(k))) begin
                errors++; $display("FAIL midrst_x%0d: got=%h required=%h", k, rf[k],
                                   (k <= 5) ? vals[k] : 32'hC0DE_0000 + 32'(k));
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++; $display("FAIL midrst_no_done: activity=%b required=0", saw_done);
        end
        for (int k = 1; k < 32; k++) rf_stage[k] = 32'h7700_0000 + 32'(k);
        push_stage(1'b1, 1'b0);
        sp_base = 32'h0000_1000; n = log_addr.size();
        run_op(1'b1, 1'b0, 200, 1'b0, d, b, ax);
        checks++;
        if (d !== 32 || log_addr.size() - n !== 31 || log_addr[n+30] !== 32'h0000_1078 || log_data[n+30] !== 32'h7700_001F) begin
            errors++; $display("FAIL midrst_resave: done=%0d count=%0d last_addr=%h last_data=%h required 32/31/00001078/7700001f",
                               d, log_addr.size() - n, log_addr[n+30], log_data[n+30]);
        end
    endtask

    initial begin
        rst_n = 1'b0; save_req = 1'b0; restore_req = 1'b0; sp_base = 32'h0;
        for (int k = 0; k < 32; k++) rf_stage[k] = 32'h0;
        for (int i = 0; i < 256; i++) mem_stage[i] = 32'h0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        push_stage(1'b1, 1'b1);
        test_save(0, 1'b0, 1'b0, "save_zero_wait");
        test_save(2, 1'b0, 1'b0, "save_wait2");
        test_restore();
        test_save(0, 1'b1, 1'b1, "priority_ignore");
        test_boundary();
        test_random();
        test_reset_mid_restore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
